// File: rtl/pe_operand_feeder.sv
// Operand feeder for a registered CSA PE: takes a tile command, pulls operand beats
// from a ready/valid source and presents them to the PE one cycle later, then drains.
module pe_operand_feeder #(
  parameter int K_W          = 8,
  parameter int T_W          = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [K_W-1:0] cmd_k_len,
  input  logic [T_W-1:0] cmd_num_tiles,
  input  logic [4:0]     cmd_shift,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_a,
  input  logic [18:0]    in_b,
  input  logic [18:0]    in_d,
  output logic [7:0]     pe_a,
  output logic [18:0]    pe_b,
  output logic [18:0]    pe_d,
  output logic           pe_valid,
  output logic [4:0]     pe_control_shift,
  output logic           pe_control_propagate,
  output logic           busy,
  output logic           done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

  logic [1:0]      state;
  logic [K_W-1:0]  k_len_q;
  logic [K_W-1:0]  beat_cnt;
  logic [T_W-1:0]  tiles_q;
  logic [T_W-1:0]  tile_cnt;
  logic [DC_W-1:0] drain_cnt;
  logic [4:0]      shift_q;
  logic            prop_flag;
  logic            done_q;

  logic cmd_fire;
  logic beat_fire;
  logic last_beat;
  logic last_tile;
  logic zero_cmd;

  logic               vld_p1;
  logic signed [7:0]  a_p1;
  logic signed [18:0] b_p1;
  logic signed [18:0] d_p1;
  logic [4:0]         shift_p1;
  logic               prop_p1;

  assign cmd_ready = (state == S_IDLE);
  assign in_ready  = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign beat_fire = in_valid & in_ready;
  // k_len_q and tiles_q are nonzero whenever RUN is active, so the minus-one never wraps.
  assign last_beat = (beat_cnt == (k_len_q - K_W'(1)));
  assign last_tile = (tile_cnt == (tiles_q - T_W'(1)));
  assign zero_cmd  = (cmd_k_len == '0) || (cmd_num_tiles == '0);

  // Control: command latch, beat/tile/drain counters, propagate flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      k_len_q   <= '0;
      tiles_q   <= '0;
      shift_q   <= '0;
      beat_cnt  <= '0;
      tile_cnt  <= '0;
      drain_cnt <= '0;
      prop_flag <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            k_len_q <= cmd_k_len;
            tiles_q <= cmd_num_tiles;
            shift_q <= cmd_shift;
            if (zero_cmd) begin
              done_q <= 1'b1;
            end else begin
              state    <= S_RUN;
              beat_cnt <= '0;
              tile_cnt <= '0;
            end
          end
        end
        S_RUN: begin
          if (beat_fire) begin
            if (last_beat) begin
              beat_cnt  <= '0;
              prop_flag <= ~prop_flag;
              if (last_tile) begin
                state     <= S_DRAIN;
                drain_cnt <= '0;
              end else begin
                tile_cnt <= tile_cnt + T_W'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + K_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: PE-side register, one cycle after the operand handshake
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1   <= 1'b0;
      a_p1     <= '0;
      b_p1     <= '0;
      d_p1     <= '0;
      shift_p1 <= '0;
      prop_p1  <= 1'b0;
    end else if (beat_fire) begin
      vld_p1   <= 1'b1;
      a_p1     <= in_a;
      b_p1     <= in_b;
      d_p1     <= (beat_cnt == '0) ? in_d : '0;
      shift_p1 <= shift_q;
      prop_p1  <= prop_flag;
    end else begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      d_p1   <= '0;
      // Outside RUN, propagate tracks the toggled flag so the PE swaps out the last tile.
      if (state != S_RUN) begin
        prop_p1 <= prop_flag;
      end
    end
  end

  assign pe_valid             = vld_p1;
  assign pe_a                 = a_p1;
  assign pe_b                 = b_p1;
  assign pe_d                 = d_p1;
  assign pe_control_shift     = shift_p1;
  assign pe_control_propagate = prop_p1;

endmodule
